// File: rtl/io_pwr_pkg.sv
// Shared definitions for the IO ring power sequencer.
//   pwr_state_e     : 3-bit sequencer state, encoding visible on state_o
//   SETTLE_CYC_DEF  : default supply settle time in clk cycles
//   ISO_CYC_DEF     : default enable/isolation spacing in clk cycles
package io_pwr_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_SETTLE = 3'd1,
    ST_EN     = 3'd2,
    ST_ON     = 3'd3,
    ST_ISO    = 3'd4,
    ST_DIS    = 3'd5,
    ST_RET    = 3'd6
  } pwr_state_e;

  localparam int unsigned SETTLE_CYC_DEF = 64;
  localparam int unsigned ISO_CYC_DEF    = 8;

endpackage

// File: rtl/io_pwr_sync.sv
// Multi-flop synchroniser for one asynchronous supply-good flag.
//   clk     : always-on clock
//   rst     : synchronous reset, active-high (clears the chain)
//   i_async : asynchronous input flag
//   o_sync  : flag synchronised to clk, STAGES cycles of latency
module io_pwr_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/io_ring_pwr_seq.sv
// Digital-side power sequencer for the 1.8V/3.3V IO ring. Steps the ring
// through pad enable, isolation release and retention in a fixed order,
// with a level req/ack handshake towards the SoC.
//   clk        : always-on clock
//   rst        : synchronous reset, active-high
//   vddio_ok_a : asynchronous VDDIO power-good
//   vdd_ok_a   : asynchronous VDD power-good
//   on_req     : 1 = ring on, 0 = ring off / retained
//   ret_mode   : power-down flavour, latched when leaving ON (1 = retention)
//   on_ack     : ring fully on
//   pad_en     : pad driver/receiver enable
//   iso_n      : core-to-pad isolation, 0 = isolated
//   ret        : pad retention latch enable
//   fault      : sticky supply-loss flag
//   state_o    : current state for debug/CSR
module io_ring_pwr_seq
  import io_pwr_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int unsigned ISO_CYC     = ISO_CYC_DEF,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vddio_ok_a,
  input  logic       vdd_ok_a,
  input  logic       on_req,
  input  logic       ret_mode,
  output logic       on_ack,
  output logic       pad_en,
  output logic       iso_n,
  output logic       ret,
  output logic       fault,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] ISO_LAST    = CNT_W'(ISO_CYC - 1);

  logic w_vddio_ok;
  logic w_vdd_ok;
  logic w_good;

  pwr_state_e       r_state;
  pwr_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ret_mode;
  logic             r_abort;
  logic             w_abort_set;
  logic             w_ret_mode_ld;

  logic r_on_ack, r_pad_en, r_iso_n, r_ret, r_fault;
  logic w_on_ack_nxt, w_pad_en_nxt, w_iso_n_nxt, w_ret_nxt, w_fault_nxt;

  io_pwr_sync #(.STAGES(SYNC_STAGES)) u_sync_vddio (
    .clk     (clk),
    .rst     (rst),
    .i_async (vddio_ok_a),
    .o_sync  (w_vddio_ok)
  );

  io_pwr_sync #(.STAGES(SYNC_STAGES)) u_sync_vdd (
    .clk     (clk),
    .rst     (rst),
    .i_async (vdd_ok_a),
    .o_sync  (w_vdd_ok)
  );

  assign w_good = w_vddio_ok & w_vdd_ok;

  // State, delay counter, latched request data and output flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_OFF;
      r_cnt      <= '0;
      r_ret_mode <= 1'b0;
      r_abort    <= 1'b0;
      r_on_ack   <= 1'b0;
      r_pad_en   <= 1'b0;
      r_iso_n    <= 1'b0;
      r_ret      <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      // Counter restarts on every state entry and saturates otherwise.
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_ret_mode_ld) begin
        r_ret_mode <= ret_mode;
      end
      if (w_abort_set) begin
        r_abort <= 1'b1;
      end else if (r_state == ST_DIS) begin
        r_abort <= 1'b0;
      end
      r_on_ack <= w_on_ack_nxt;
      r_pad_en <= w_pad_en_nxt;
      r_iso_n  <= w_iso_n_nxt;
      r_ret    <= w_ret_nxt;
      r_fault  <= w_fault_nxt;
    end
  end

  // Supply loss while the pads are powered is routed through ISO (isolate
  // first) and DIS (drop drivers next) so the teardown order matches the
  // orderly power-down; r_abort makes ISO skip its hold time.
  always_comb begin
    w_state_nxt   = r_state;
    w_abort_set   = 1'b0;
    w_ret_mode_ld = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (on_req && w_good) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!w_good)                   w_state_nxt = ST_OFF;
        else if (r_cnt == SETTLE_LAST) w_state_nxt = ST_EN;
      end
      ST_EN: begin
        if (!w_good) begin
          w_state_nxt = ST_ISO;
          w_abort_set = 1'b1;
        end else if (r_cnt == ISO_LAST) begin
          w_state_nxt = ST_ON;
        end
      end
      ST_ON: begin
        if (!w_good) begin
          w_state_nxt = ST_ISO;
          w_abort_set = 1'b1;
        end else if (!on_req) begin
          w_state_nxt   = ST_ISO;
          w_ret_mode_ld = 1'b1;
        end
      end
      ST_ISO: begin
        if (r_abort) begin
          w_state_nxt = ST_DIS;
        end else if (!w_good) begin
          w_abort_set = 1'b1;
        end else if (r_cnt == ISO_LAST) begin
          w_state_nxt = r_ret_mode ? ST_RET : ST_DIS;
        end
      end
      ST_DIS: begin
        w_state_nxt = ST_OFF;
      end
      ST_RET: begin
        if (on_req && w_good) w_state_nxt = ST_SETTLE;
      end
      default: begin
        w_state_nxt = ST_OFF;
      end
    endcase
  end

  // Output values for the state being entered, so outputs change on the
  // same edge as the state.
  always_comb begin
    w_on_ack_nxt = (w_state_nxt == ST_ON);
    w_iso_n_nxt  = (w_state_nxt == ST_ON);
    w_pad_en_nxt = (w_state_nxt == ST_EN) || (w_state_nxt == ST_ON) ||
                   (w_state_nxt == ST_ISO);
    // Retention is held through the following SETTLE/EN re-power and
    // released only once the ring is fully back on.
    w_ret_nxt = r_ret;
    if (w_state_nxt == ST_RET) begin
      w_ret_nxt = 1'b1;
    end else if ((r_state == ST_EN) && (w_state_nxt == ST_ON)) begin
      w_ret_nxt = 1'b0;
    end
    w_fault_nxt = r_fault;
    if (!w_good && ((r_state == ST_EN) || (r_state == ST_ON) ||
                    (r_state == ST_ISO) || (r_state == ST_DIS) ||
                    (r_state == ST_RET))) begin
      w_fault_nxt = 1'b1;
    end
  end

  assign on_ack  = r_on_ack;
  assign pad_en  = r_pad_en;
  assign iso_n   = r_iso_n;
  assign ret     = r_ret;
  assign fault   = r_fault;
  assign state_o = r_state;

endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// Directed bench for io_ring_pwr_seq with default parameters
// (SYNC_STAGES=2, SETTLE_CYC=64, ISO_CYC=8). Inputs change and outputs are
// sampled on the falling edge; "+N" below means N rising edges later.
module tb_io_ring_pwr_seq;

  localparam logic [2:0] S_OFF    = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_EN     = 3'd2;
  localparam logic [2:0] S_ON     = 3'd3;
  localparam logic [2:0] S_ISO    = 3'd4;
  localparam logic [2:0] S_DIS    = 3'd5;
  localparam logic [2:0] S_RET    = 3'd6;

  logic       clk;
  logic       rst;
  logic       vddio_ok_a;
  logic       vdd_ok_a;
  logic       on_req;
  logic       ret_mode;
  logic       on_ack;
  logic       pad_en;
  logic       iso_n;
  logic       ret;
  logic       fault;
  logic [2:0] state_o;

  int unsigned n_checks;
  int unsigned n_pass;

  io_ring_pwr_seq #(
    .SYNC_STAGES (2),
    .SETTLE_CYC  (64),
    .ISO_CYC     (8),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vddio_ok_a (vddio_ok_a),
    .vdd_ok_a   (vdd_ok_a),
    .on_req     (on_req),
    .ret_mode   (ret_mode),
    .on_ack     (on_ack),
    .pad_en     (pad_en),
    .iso_n      (iso_n),
    .ret        (ret),
    .fault      (fault),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    vddio_ok_a = 1'b0;
    vdd_ok_a   = 1'b0;
    on_req     = 1'b0;
    ret_mode   = 1'b0;

    // Reset values
    step(3);
    check("rst_outs", 32'({on_ack, pad_en, iso_n, ret, fault}), 32'd0);
    check("rst_state", 32'(state_o), 32'(S_OFF));
    rst = 1'b0;
    step(4);
    check("idle_state", 32'(state_o), 32'(S_OFF));

    // Power-up: supplies and request together (sampled at A+1).
    // good at A+2, SETTLE at A+3, EN (pad_en) at A+67, ON at A+75.
    vddio_ok_a = 1'b1;
    vdd_ok_a   = 1'b1;
    on_req     = 1'b1;
    step(2);
    check("pu_sync_wait", 32'(state_o), 32'(S_OFF));
    step(1);
    check("pu_settle", 32'(state_o), 32'(S_SETTLE));
    step(63);
    check("pu_pad_en_pre", 32'(pad_en), 32'd0);
    step(1);
    check("pu_pad_en", 32'(pad_en), 32'd1);
    check("pu_en_state", 32'(state_o), 32'(S_EN));
    check("pu_en_iso", 32'(iso_n), 32'd0);
    step(7);
    check("pu_ack_pre", 32'(on_ack), 32'd0);
    step(1);
    check("pu_ack", 32'({on_ack, iso_n, pad_en}), 32'b111);
    check("pu_on_state", 32'(state_o), 32'(S_ON));

    // Power-down, full off: ISO at B+1, DIS at B+9, OFF at B+10.
    step(3);
    on_req   = 1'b0;
    ret_mode = 1'b0;
    step(1);
    check("pd_iso", 32'({on_ack, iso_n, pad_en}), 32'b001);
    check("pd_iso_state", 32'(state_o), 32'(S_ISO));
    ret_mode = 1'b1;  // change after ON exit must be ignored
    step(7);
    check("pd_pad_en_hold", 32'(pad_en), 32'd1);
    step(1);
    check("pd_pad_en_off", 32'(pad_en), 32'd0);
    check("pd_dis_state", 32'(state_o), 32'(S_DIS));
    step(1);
    check("pd_off_state", 32'(state_o), 32'(S_OFF));
    check("pd_ret_fault", 32'({ret, fault}), 32'd0);
    ret_mode = 1'b0;

    // Second power-up with good already high: SETTLE at C+1,
    // pad_en at C+65, on_ack at C+73 (1+64+8 after first on_req&good).
    on_req = 1'b1;
    step(64);
    check("pu2_pad_en_pre", 32'(pad_en), 32'd0);
    step(1);
    check("pu2_pad_en", 32'(pad_en), 32'd1);
    step(7);
    check("pu2_ack_pre", 32'(on_ack), 32'd0);
    step(1);
    check("pu2_ack", 32'(on_ack), 32'd1);

    // Retention: ISO at D+1, RET at D+9.
    step(2);
    on_req   = 1'b0;
    ret_mode = 1'b1;
    step(1);
    ret_mode = 1'b0;  // already latched
    step(7);
    check("ret_pre", 32'(ret), 32'd0);
    check("ret_pre_state", 32'(state_o), 32'(S_ISO));
    step(1);
    check("ret_set", 32'({ret, pad_en, iso_n}), 32'b100);
    check("ret_state", 32'(state_o), 32'(S_RET));
    step(5);
    check("ret_hold", 32'({ret, state_o}), {28'd0, 1'b1, S_RET});
    // Wake from retention: SETTLE at E+1, EN at E+65, ON at E+73.
    on_req = 1'b1;
    step(1);
    check("wake_settle", 32'({ret, state_o}), {28'd0, 1'b1, S_SETTLE});
    step(64);
    check("wake_en", 32'({ret, pad_en, state_o}), {27'd0, 2'b11, S_EN});
    step(7);
    check("wake_overlap", 32'({ret, pad_en, iso_n}), 32'b110);
    step(1);
    check("wake_on", 32'({ret, iso_n, on_ack}), 32'b011);

    // Supply fault in ON: VDDIO low sampled at F+1, good low at F+2,
    // isolate at F+3, pad_en off at F+4, OFF at F+5.
    step(2);
    vddio_ok_a = 1'b0;
    step(2);
    check("flt_iso_pre", 32'({iso_n, fault}), 32'b10);
    step(1);
    check("flt_iso", 32'({iso_n, on_ack, pad_en, fault}), 32'b0011);
    step(1);
    check("flt_pad_off", 32'(pad_en), 32'd0);
    step(1);
    check("flt_off", 32'({fault, state_o}), {28'd0, 1'b1, S_OFF});

    // Restore supply with on_req still high: SETTLE at G+3, EN at G+67.
    vddio_ok_a = 1'b1;
    step(67);
    check("flt_sticky_en", 32'({fault, state_o}), {28'd0, 1'b1, S_EN});
    step(2);

    // Reset mid-EN: everything back to reset values on the next edge.
    rst = 1'b1;
    step(1);
    check("rst_mid_outs", 32'({on_ack, pad_en, iso_n, ret, fault}), 32'd0);
    check("rst_mid_state", 32'(state_o), 32'(S_OFF));
    rst    = 1'b0;
    on_req = 1'b0;
    step(5);

    // VDD glitch during SETTLE: SETTLE at H+1 (count 30 at H+31),
    // good low H+33..H+35 -> OFF at H+34, SETTLE again at H+37,
    // pad_en at H+101, fault untouched.
    on_req = 1'b1;
    step(31);
    check("gl_settle", 32'(state_o), 32'(S_SETTLE));
    vdd_ok_a = 1'b0;
    step(2);
    check("gl_settle_still", 32'(state_o), 32'(S_SETTLE));
    step(1);
    check("gl_off", 32'({fault, state_o}), {28'd0, 1'b0, S_OFF});
    vdd_ok_a = 1'b1;
    step(2);
    check("gl_off_hold", 32'(state_o), 32'(S_OFF));
    step(1);
    check("gl_resettle", 32'(state_o), 32'(S_SETTLE));
    step(63);
    check("gl_pad_en_pre", 32'(pad_en), 32'd0);
    step(1);
    check("gl_pad_en", 32'({pad_en, fault}), 32'b10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
